sdram_arb: RTL
==============

# sdram_arb

Request scheduler in front of the SDRAM command engines of the OV7670 frame-buffer path. It owns the auto-refresh interval timer and grants the single SDRAM command bus to one of three clients:
- auto-refresh engine
- camera write engine
- display read engine

Grants are one-hot and sequenced as INIT → IDLE → {AREF | WRITE | READ} → IDLE. The block holds all grants off until power-up initialisation reports done.

## Interface
Parameters:
- REF_CYC, 780, refresh interval in sclk cycles (7.8 µs at 100 MHz); legal range 8..2^CNT_W-1
- CNT_W, 10, refresh counter width

Ports:
- sclk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- init_done  in  1  level from init engine; 1 = power-up sequence complete
- wr_req  in  1  camera write engine has a burst pending (level)
- wr_done  in  1  one-cycle pulse, write burst finished, bus released
- rd_req  in  1  display read engine has a burst pending (level)
- rd_done  in  1  one-cycle pulse, read burst finished
- aref_done  in  1  one-cycle pulse, auto-refresh finished
- wr_en  out  1  write grant
- rd_en  out  1  read grant
- aref_en  out  1  refresh grant
- ref_pending  out  1  refresh due; the active engine must end at its next burst boundary
- ref_overrun  out  1  sticky error: interval expired while a refresh was still pending
- arb_state  out  4  one-hot state: INIT=0001, IDLE=0010, WRITE=0100, READ=1000; AREF is reported as 0011

## Operation
- **Reset (async, immediate):**
  - state = INIT
  - wr_en = rd_en = aref_en = 0
  - ref_pending = ref_overrun = 0
  - refresh counter = 0
  - RR flag last_wr = 0
- **INIT:** all grants 0 and the counter is held at 0. When init_done = 1 is sampled, the next state is IDLE. init_done is ignored after leaving INIT.
- **Refresh timer:**
  - Counts every cycle while state ≠ INIT.
  - At count REF_CYC-1 it wraps to 0 and sets ref_pending on the next edge.
  - ref_pending clears on the edge where aref_done is sampled in AREF.
  - If the wrap occurs while ref_pending = 1, ref_overrun is set and stays set until rst.
  - If the wrap and aref_done coincide, ref_pending stays 1 and no overrun is raised.
- **IDLE, in priority order:**
  1. ref_pending → AREF
  2. wr_req/rd_req selection (see Configuration)
  3. none → stay in IDLE
- **AREF / WRITE / READ:**
  - The matching grant is high for every cycle of the state.
  - The state exits to IDLE on the edge where its own done pulse is sampled.
- **Done and request pulses:**
  - done pulses arriving in any other state are ignored.
  - A request dropping mid-grant has no effect; the engine keeps the bus until its done pulse.
- Grants are registered outputs decoded from the next state. At most one grant is ever high.

## Timing
- Request latency: req sampled in IDLE at edge n → grant high after edge n (visible from cycle n+1).
- Release: done sampled at edge m → grant low after edge m.
- There is at least one IDLE cycle between consecutive grants.
- ref_pending rises exactly REF_CYC cycles after the counter leaves reset and every REF_CYC cycles thereafter, independent of grant activity.
- Reset mid-grant drops the grant combinationally via the async clear, without waiting for an edge. The engine aborts its burst.

## Configuration
- Macro `SDRAM_ARB_RR_EN` selects how IDLE chooses between wr_req and rd_req.
- **Defined:** round-robin between write and read.
  - If both are requesting, grant the one not served last.
  - last_wr updates on each WRITE/READ entry; reset 0, so the first tie goes to write.
- **Undefined:** fixed priority, write over read. The camera must never stall; read can starve. last_wr is not implemented.
- Refresh always has top priority in both builds.

## Structure
- **Package sdram_pkg:**
  - state encodings (INIT, IDLE, AREF, WRITE, READ)
  - SDRAM command codes (NOP, ACT, WR, RD, BSTP, PR, AR, LMR) shared with the command engines
  - default REF_CYC
- **Sub-module sdram_ref_timer:**
  - contents: counter, wrap detect, ref_pending set/clear, ref_overrun
  - inputs: run, aref_done
  - outputs: ref_pending, ref_overrun
- The arbiter FSM instantiates this timer.

## Test plan
- **Init hold:** rst pulse, then init_done = 0 for 100 cycles → all grants 0, arb_state = 0001. Raise init_done → arb_state = 0010 one cycle later.
- **Refresh cadence (REF_CYC = 16):** idle bench → ref_pending rises 16 cycles after IDLE entry, aref_en the next cycle. aref_done → ref_pending 0, IDLE, next ref_pending 16 cycles after the previous one.
- **Contention:** wr_req = rd_req = 1 constantly, each done 4 cycles after its grant.
  - With SDRAM_ARB_RR_EN, the grant order is W,R,W,R.
  - Without it, the order is W,W,W and rd_en stays 0.
- **Refresh during write:** ref_pending rises in WRITE → wr_en stays 1 until wr_done. Then AREF is granted before the queued rd_req.
- **Overrun:** hold WRITE without wr_done for 2×REF_CYC → ref_overrun = 1 and it stays 1 after the later wr_done and aref_done.
- **Async reset mid-READ:** assert rst between edges → rd_en = 0 immediately, arb_state = 0001, ref_pending = 0.

Source files
------------

// File: rtl/sdram_pkg.sv
// sdram_pkg: shared state and command encodings for the SDRAM frame-buffer path
//   arb_state_t : one-hot arbiter states (AREF reported as 0011)
//   sdram_cmd_t : SDRAM command codes {cs_n, ras_n, cas_n, we_n} used by the engines
//   REF_CYC_DEF : default refresh interval (7.8 us at 100 MHz)
package sdram_pkg;
    typedef enum logic [3:0] {
        INIT  = 4'b0001,
        IDLE  = 4'b0010,
        AREF  = 4'b0011,
        WRITE = 4'b0100,
        READ  = 4'b1000
    } arb_state_t;
    typedef enum logic [3:0] {
        CMD_NOP  = 4'b0111,
        CMD_ACT  = 4'b0011,
        CMD_WR   = 4'b0100,
        CMD_RD   = 4'b0101,
        CMD_BSTP = 4'b0110,
        CMD_PR   = 4'b0010,
        CMD_AR   = 4'b0001,
        CMD_LMR  = 4'b0000
    } sdram_cmd_t;
    localparam int REF_CYC_DEF = 780;
endpackage

// File: rtl/sdram_ref_timer.sv
// sdram_ref_timer: auto-refresh interval timer with pending and sticky overrun flags
//   sclk, rst      : clock, async active-high reset
//   run            : count enable; counter held at 0 while low
//   aref_done      : refresh finished (already qualified by the AREF state)
//   ref_pending    : refresh due, set on wrap, cleared by aref_done
//   ref_overrun    : sticky, interval expired while a refresh was still pending
module sdram_ref_timer
    import sdram_pkg::*;
#(
    parameter int REF_CYC = REF_CYC_DEF,
    parameter int CNT_W   = 10
) (
    input  logic sclk,
    input  logic rst,
    input  logic run,
    input  logic aref_done,
    output logic ref_pending,
    output logic ref_overrun
);
    logic [CNT_W-1:0] cnt;
    logic             wrap;
    assign wrap = run && cnt == CNT_W'(REF_CYC - 1);
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            ref_pending <= 1'b0;
            ref_overrun <= 1'b0;
        end else begin
            cnt         <= (!run || wrap) ? '0 : cnt + 1'b1;
            // a wrap re-arms the request even when the previous refresh finishes on the same edge
            ref_pending <= wrap | (ref_pending & ~aref_done);
            if (wrap && ref_pending && !aref_done)
                ref_overrun <= 1'b1;
        end
    end
endmodule

// File: rtl/sdram_arb.sv
// sdram_arb: grants the SDRAM command bus to refresh, camera write or display read
//   sclk, rst                 : clock, async active-high reset
//   init_done                 : power-up sequence complete (only looked at in INIT)
//   wr_req/rd_req             : burst pending levels from write/read engines
//   wr_done/rd_done/aref_done : one-cycle release pulses, honoured only in the matching state
//   wr_en/rd_en/aref_en       : registered one-hot grants
//   ref_pending/ref_overrun   : refresh due / sticky missed-refresh error
//   arb_state                 : current state (one-hot, AREF = 0011)
// Macro SDRAM_ARB_RR_EN: round-robin between write and read; default is write-over-read priority.
module sdram_arb
    import sdram_pkg::*;
#(
    parameter int REF_CYC = REF_CYC_DEF,
    parameter int CNT_W   = 10
) (
    input  logic       sclk,
    input  logic       rst,
    input  logic       init_done,
    input  logic       wr_req,
    input  logic       wr_done,
    input  logic       rd_req,
    input  logic       rd_done,
    input  logic       aref_done,
    output logic       wr_en,
    output logic       rd_en,
    output logic       aref_en,
    output logic       ref_pending,
    output logic       ref_overrun,
    output logic [3:0] arb_state
);
    arb_state_t state, nxt;
    logic       pick_wr;
    sdram_ref_timer #(.REF_CYC(REF_CYC), .CNT_W(CNT_W)) u_timer (
        .sclk        (sclk),
        .rst         (rst),
        .run         (state != INIT),
        .aref_done   (state == AREF && aref_done),
        .ref_pending (ref_pending),
        .ref_overrun (ref_overrun)
    );
`ifdef SDRAM_ARB_RR_EN
    logic last_wr;
    // on a tie, serve whichever side was not served last
    assign pick_wr = wr_req && !(rd_req && last_wr);
    always_ff @(posedge sclk or posedge rst) begin
        if (rst)
            last_wr <= 1'b0;
        else if (nxt == WRITE || nxt == READ)
            last_wr <= nxt == WRITE;
    end
`else
    assign pick_wr = wr_req;
`endif
    always_comb begin
        nxt = state;
        case (state)
            INIT:    nxt = init_done ? IDLE : INIT;
            IDLE:    nxt = ref_pending ? AREF : pick_wr ? WRITE : rd_req ? READ : IDLE;
            AREF:    nxt = aref_done ? IDLE : AREF;
            WRITE:   nxt = wr_done ? IDLE : WRITE;
            READ:    nxt = rd_done ? IDLE : READ;
            default: nxt = INIT;
        endcase
    end
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state   <= INIT;
            wr_en   <= 1'b0;
            rd_en   <= 1'b0;
            aref_en <= 1'b0;
        end else begin
            state   <= nxt;
            wr_en   <= nxt == WRITE;
            rd_en   <= nxt == READ;
            aref_en <= nxt == AREF;
        end
    end
    assign arb_state = state;
endmodule
